timing_ref_arb: RTL and testbench
=================================

# timing_ref_arb

Automatic reference-clock arbiter that sits directly upstream of the `timing` block. It consumes the `timing` block's per-reference `clk_loss` indications and a 1 ms tick, qualifies each reference with hold-off and wait-to-restore timers, and picks the best qualified reference by priority. It runs a FREERUN/LOCKED/HOLDOVER state machine. It drives one `ref_sel` lane (and its `ref_en` bit) of `timing`.

## Interface
Parameters:
- `NUM_REF`, 11: number of monitored references; matches the `clk_loss` width.
- `SEL_W`, 4: width of a reference index.
- `HOLDOFF_MS`, 100: consecutive ms of loss before a qualified reference is dropped.
- `WTR_MS`, 1000: consecutive clean ms before a reference is (re)qualified.

Ports:
- `clk_125m  in  1`: the only clock.
- `rst  in  1`: synchronous, active-high reset.
- `tick_1ms  in  1`: one-cycle pulse every 1 ms, already in the `clk_125m` domain.
- `clk_loss  in  NUM_REF`: per-reference loss flag from `timing`, level.
- `ref_cfg_en  in  NUM_REF`: software enable per reference.
- `ref_prio  in  NUM_REF×4`: priority per reference; 0 is highest.
- `revertive  in  1`: 1 means return to a strictly better reference once it requalifies.
- `force_en  in  1`: manual selection request.
- `force_sel  in  SEL_W`: manually requested reference index.
- `sel_ref  out  SEL_W`: selected reference index.
- `sel_valid  out  1`: `sel_ref` is currently qualified; feeds the `ref_en` lane.
- `arb_state  out  2`: 0 FREERUN, 1 LOCKED, 2 HOLDOVER.
- `qualified  out  NUM_REF`: per-reference qualification status.
- `switch_evt  out  1`: one-cycle pulse on every change of `sel_ref` or `arb_state`.

## Operation
Per-reference qualification, for each reference i:
- If `ref_cfg_en[i]`=0: `qualified[i]`←0 and the counter clears, both on the next edge.
- While unqualified: any cycle with `clk_loss[i]`=1 clears the counter. Each `tick_1ms` with loss=0 increments it.
  - When the counter reaches `WTR_MS`, `qualified[i]`←1 and the counter clears.
- While qualified: any cycle with loss=0 clears the counter. Each tick with loss=1 increments it.
  - When the counter reaches `HOLDOFF_MS`, `qualified[i]`←0.
  - With `HOLDOFF_MS`=0, the reference drops on the edge after loss is first sampled.
- Counter width is `$clog2(max(HOLDOFF_MS,WTR_MS)+1)`. Counters saturate and never wrap.

Best candidate:
- The qualified reference with the lowest `ref_prio`.
- Ties go to the lowest index.

State machine:
- FREERUN (reset state):
  - Any reference qualified → LOCKED, `sel_ref`=best.
- LOCKED:
  - Current reference disqualified and another qualified → switch to best, stay LOCKED.
  - Current reference disqualified and none qualified → HOLDOVER.
  - `revertive`=1 and best has strictly lower `ref_prio` than current → switch to best.
  - Equal priority never causes a switch.
- HOLDOVER:
  - `sel_ref` holds its last value and `sel_valid`=0.
  - Any reference qualified → LOCKED at best.
- Simultaneous events in one cycle: disqualification of the current reference is evaluated before any revertive switch.

## Timing
- Reset values: `sel_ref`=0, `sel_valid`=0, `arb_state`=FREERUN, `qualified`=0, `switch_evt`=0. All counters=0.
- A `qualified` change at edge N updates `sel_ref`, `sel_valid` and `arb_state` at edge N+1.
- `switch_evt` is high for exactly the cycle following edge N+1.
- `sel_valid`=1 exactly when `arb_state`=LOCKED.
- `rst` asserted mid-operation returns everything to reset values on the next edge. Requalification then takes the full `WTR_MS`.

## Configuration
Macro `TIMING_REF_FORCE_EN`:
- Defined:
  - `force_en`=1 with `force_sel`<`NUM_REF` and that reference qualified → select `force_sel`, overriding priority and `revertive`.
  - Force target unqualified, or `force_sel`≥`NUM_REF` → automatic arbitration.
- Undefined: `force_en` and `force_sel` are present but ignored; behaviour is purely automatic.

## Structure
- `timing_pkg` holds:
  - the `arb_state_t` enum (FREERUN, LOCKED, HOLDOVER);
  - `NUM_REF_DEF`=11;
  - `SEL_W_DEF`=4;
  - the `ref_prio_t` typedef (4 bits).
- Sub-module `timing_ref_qual`: one per reference, instantiated `NUM_REF` times. Contains the hold-off/WTR counter and the `qualified` flop.
- Top level holds the best-candidate compare tree and the state machine.

## Test plan
Bench parameters: `HOLDOFF_MS`=2, `WTR_MS`=5, `ref_prio[i]`=i, all references enabled and clean.
1. Release reset, issue 5 ticks → all `qualified`=1. One cycle later: LOCKED, `sel_ref`=0, `sel_valid`=1, one `switch_evt` pulse.
2. `clk_loss[0]` high across 1 tick, then low → no switch, `qualified[0]` stays 1.
3. `clk_loss[0]` held for 2 ticks → `qualified[0]`=0, then `sel_ref`=1 with one `switch_evt`.
4. Clear `clk_loss[0]`:
   - `revertive`=1 → `sel_ref`=0 after 5 ticks plus 1 cycle.
   - `revertive`=0 → `sel_ref` stays 1.
5. All `clk_loss` high for 2 ticks → HOLDOVER, `sel_valid`=0, `sel_ref` held. Clear `clk_loss[3]` only → LOCKED, `sel_ref`=3 after 5 ticks.
6. With `TIMING_REF_FORCE_EN` defined:
   - `force_en`=1, `force_sel`=4 → `sel_ref`=4 next cycle.
   - `force_sel`=12 → automatic selection, `sel_ref`=0.
   - Assert `rst` mid-run → all outputs return to reset values next edge.

Source files
------------

// File: rtl/timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timing_pkg
// Description : Shared types and defaults for the reference-clock arbiter.
//               arb_state_t - FREERUN / LOCKED / HOLDOVER encoding
//               ref_prio_t  - 4-bit per-reference priority (0 = highest)
// Revision    : 1.0 - initial release
// ============================================================================
package timing_pkg;

    typedef enum logic [1:0] {
        FREERUN  = 2'd0,
        LOCKED   = 2'd1,
        HOLDOVER = 2'd2
    } arb_state_t;

    localparam int NUM_REF_DEF = 11;
    localparam int SEL_W_DEF   = 4;

    typedef logic [3:0] ref_prio_t;

endpackage
`default_nettype wire

// File: rtl/timing_ref_qual.sv
`default_nettype none
// ============================================================================
// Module      : timing_ref_qual
// Description : Qualification of one reference. Counts 1 ms ticks of clean
//               signal (wait-to-restore) before qualifying, and 1 ms ticks of
//               loss (hold-off) before disqualifying. Saturating counter.
// Ports       : clk_125m, rst  - clock, synchronous active-high reset
//               tick_1ms       - 1 ms strobe
//               cfg_en         - software enable for this reference
//               clk_loss       - loss flag (level)
//               qualified      - registered qualification status
// Revision    : 1.0 - initial release
// ============================================================================
module timing_ref_qual #(
    parameter int HOLDOFF_MS = 100,
    parameter int WTR_MS     = 1000
) (
    input  logic clk_125m,
    input  logic rst,
    input  logic tick_1ms,
    input  logic cfg_en,
    input  logic clk_loss,
    output logic qualified
);

    localparam int CNT_MAX = (HOLDOFF_MS > WTR_MS) ? HOLDOFF_MS : WTR_MS;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] c_wtr  = CNT_W'(WTR_MS);
    localparam logic [CNT_W-1:0] c_hold = CNT_W'(HOLDOFF_MS);

    logic             r_qual;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturating increment: the counter never wraps back to zero.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk_125m) begin
        if (rst || !cfg_en) begin
            r_qual <= 1'b0;
            r_cnt  <= '0;
        end else if (!r_qual) begin
            // Wait-to-restore: any loss restarts the clean-time count.
            if (clk_loss) begin
                r_cnt <= '0;
            end else if (WTR_MS == 0) begin
                r_qual <= 1'b1;
                r_cnt  <= '0;
            end else if (tick_1ms) begin
                if (w_cnt_inc >= c_wtr) begin
                    r_qual <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end else begin
            // Hold-off: any clean cycle restarts the loss-time count.
            if (!clk_loss) begin
                r_cnt <= '0;
            end else if (HOLDOFF_MS == 0) begin
                r_qual <= 1'b0;
            end else if (tick_1ms) begin
                if (w_cnt_inc >= c_hold) begin
                    r_qual <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign qualified = r_qual;

endmodule
`default_nettype wire

// File: rtl/timing_ref_arb.sv
`default_nettype none
// ============================================================================
// Module      : timing_ref_arb
// Description : Automatic reference-clock arbiter. Qualifies each reference
//               (hold-off / wait-to-restore), picks the qualified reference
//               with the lowest priority value (ties to lowest index) and
//               runs a FREERUN / LOCKED / HOLDOVER state machine.
// Ports       : clk_125m, rst            - clock, sync active-high reset
//               tick_1ms                 - 1 ms strobe
//               clk_loss, ref_cfg_en     - per-reference loss / enable
//               ref_prio                 - 4 bits per reference, 0 highest
//               revertive                - return to strictly better ref
//               force_en, force_sel      - manual selection request
//               sel_ref, sel_valid       - selected reference / valid
//               arb_state                - 0 FREERUN, 1 LOCKED, 2 HOLDOVER
//               qualified                - per-reference qualification
//               switch_evt               - pulse on sel_ref/arb_state change
// Config      : TIMING_REF_FORCE_EN - when defined, force_en/force_sel select
//               a qualified reference manually; otherwise they are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module timing_ref_arb
    import timing_pkg::*;
#(
    parameter int NUM_REF    = NUM_REF_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int HOLDOFF_MS = 100,
    parameter int WTR_MS     = 1000
) (
    input  logic                 clk_125m,
    input  logic                 rst,
    input  logic                 tick_1ms,
    input  logic [NUM_REF-1:0]   clk_loss,
    input  logic [NUM_REF-1:0]   ref_cfg_en,
    input  logic [NUM_REF*4-1:0] ref_prio,
    input  logic                 revertive,
    input  logic                 force_en,
    input  logic [SEL_W-1:0]     force_sel,
    output logic [SEL_W-1:0]     sel_ref,
    output logic                 sel_valid,
    output logic [1:0]           arb_state,
    output logic [NUM_REF-1:0]   qualified,
    output logic                 switch_evt
);

    // ------------------------------------------------------------------
    // Per-reference qualification
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REF; gi++) begin : g_qual
        timing_ref_qual #(
            .HOLDOFF_MS (HOLDOFF_MS),
            .WTR_MS     (WTR_MS)
        ) u_qual (
            .clk_125m  (clk_125m),
            .rst       (rst),
            .tick_1ms  (tick_1ms),
            .cfg_en    (ref_cfg_en[gi]),
            .clk_loss  (clk_loss[gi]),
            .qualified (qualified[gi])
        );
    end

    // ------------------------------------------------------------------
    // Best candidate and current-reference lookup
    // ------------------------------------------------------------------
    arb_state_t       r_state;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic             r_evt;

    logic             w_any;
    logic [SEL_W-1:0] w_best;
    ref_prio_t        w_best_prio;
    logic             w_cur_q;
    ref_prio_t        w_cur_prio;

    always_comb begin
        w_any       = 1'b0;
        w_best      = '0;
        w_best_prio = '1;
        w_cur_q     = 1'b0;
        w_cur_prio  = '1;
        for (int i = 0; i < NUM_REF; i++) begin
            // Strict compare keeps the lowest index on equal priority.
            if (qualified[i] && (!w_any || ref_prio[i*4 +: 4] < w_best_prio)) begin
                w_any       = 1'b1;
                w_best      = SEL_W'(i);
                w_best_prio = ref_prio[i*4 +: 4];
            end
            if (r_sel == SEL_W'(i)) begin
                w_cur_q    = qualified[i];
                w_cur_prio = ref_prio[i*4 +: 4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Manual override (build option)
    // ------------------------------------------------------------------
    logic             w_force_ok;
    logic [SEL_W-1:0] w_target;

`ifdef TIMING_REF_FORCE_EN
    // Only indices below NUM_REF can match, so out-of-range requests fall
    // back to automatic arbitration.
    always_comb begin
        w_force_ok = 1'b0;
        for (int i = 0; i < NUM_REF; i++) begin
            if (force_en && force_sel == SEL_W'(i) && qualified[i]) begin
                w_force_ok = 1'b1;
            end
        end
    end
    assign w_target = w_force_ok ? force_sel : w_best;
`else
    logic w_unused_force;
    assign w_unused_force = ^{force_en, force_sel};
    assign w_force_ok     = 1'b0;
    assign w_target       = w_best;
`endif

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    arb_state_t       w_nxt_state;
    logic [SEL_W-1:0] w_nxt_sel;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = r_sel;
        case (r_state)
            FREERUN, HOLDOVER: begin
                if (w_any) begin
                    w_nxt_state = LOCKED;
                    w_nxt_sel   = w_target;
                end
            end
            LOCKED: begin
                // Loss of the current reference takes precedence over a
                // revertive switch decided in the same cycle.
                if (w_force_ok) begin
                    w_nxt_sel = w_target;
                end else if (!w_cur_q) begin
                    if (w_any) begin
                        w_nxt_sel = w_best;
                    end else begin
                        w_nxt_state = HOLDOVER;
                    end
                end else if (revertive && w_best_prio < w_cur_prio) begin
                    w_nxt_sel = w_best;
                end
            end
            default: begin
                w_nxt_state = FREERUN;
            end
        endcase
    end

    always_ff @(posedge clk_125m) begin
        if (rst) begin
            r_state <= FREERUN;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_valid <= (w_nxt_state == LOCKED);
            r_evt   <= (w_nxt_state != r_state) || (w_nxt_sel != r_sel);
        end
    end

    assign sel_ref    = r_sel;
    assign sel_valid  = r_valid;
    assign arb_state  = r_state;
    assign switch_evt = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_timing_ref_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_timing_ref_arb
// Description : Self-checking bench for timing_ref_arb with HOLDOFF_MS=2,
//               WTR_MS=5, ref_prio[i]=i. Every expected switch is queued by
//               the stimulus; a monitor pops and compares on each switch_evt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timing_ref_arb;

    localparam int NR = 11;
    localparam int SW = 4;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [1:0]    st;
        logic          v;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick_1ms;
    logic [NR-1:0]  clk_loss;
    logic [NR-1:0]  ref_cfg_en;
    logic [NR*4-1:0] ref_prio;
    logic           revertive;
    logic           force_en;
    logic [SW-1:0]  force_sel;
    logic [SW-1:0]  sel_ref;
    logic           sel_valid;
    logic [1:0]     arb_state;
    logic [NR-1:0]  qualified;
    logic           switch_evt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #4 clk = ~clk;

    timing_ref_arb #(
        .NUM_REF    (NR),
        .SEL_W      (SW),
        .HOLDOFF_MS (2),
        .WTR_MS     (5)
    ) dut (
        .clk_125m   (clk),
        .rst        (rst),
        .tick_1ms   (tick_1ms),
        .clk_loss   (clk_loss),
        .ref_cfg_en (ref_cfg_en),
        .ref_prio   (ref_prio),
        .revertive  (revertive),
        .force_en   (force_en),
        .force_sel  (force_sel),
        .sel_ref    (sel_ref),
        .sel_valid  (sel_valid),
        .arb_state  (arb_state),
        .qualified  (qualified),
        .switch_evt (switch_evt)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int sel, input int st, input int v);
        exp_t e;
        e.sel = SW'(sel);
        e.st  = 2'(st);
        e.v   = 1'(v);
        exp_q.push_back(e);
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick_1ms = 1'b1;
        @(negedge clk);
        tick_1ms = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    // Monitor: every switch_evt pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (switch_evt) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_switch: sel_ref=%0d state=%0d, expected no switch",
                         sel_ref, arb_state);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("evt_sel_ref",   int'(sel_ref),   int'(e.sel));
                check("evt_arb_state", int'(arb_state), int'(e.st));
                check("evt_sel_valid", int'(sel_valid), int'(e.v));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        tick_1ms   = 1'b0;
        clk_loss   = '0;
        ref_cfg_en = '1;
        revertive  = 1'b1;
        force_en   = 1'b0;
        force_sel  = '0;
        for (int i = 0; i < NR; i++) ref_prio[i*4 +: 4] = 4'(i);

        repeat (3) @(negedge clk);
        check("rst_sel_ref",    int'(sel_ref),    0);
        check("rst_sel_valid",  int'(sel_valid),  0);
        check("rst_arb_state",  int'(arb_state),  0);
        check("rst_qualified",  int'(qualified),  0);
        check("rst_switch_evt", int'(switch_evt), 0);
        rst = 1'b0;

        // 1. Initial qualification after WTR.
        ticks(4);
        check("wtr_4_ticks_unqual", int'(qualified), 0);
        push(0, 1, 1);
        ticks(1);
        check("wtr_5_ticks_qual", int'(qualified), 11'h7FF);
        check("lock_sel_valid",   int'(sel_valid), 1);

        // 2. Loss shorter than hold-off is ignored.
        clk_loss[0] = 1'b1;
        ticks(1);
        clk_loss[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("short_loss_qual0", int'(qualified[0]), 1);
        check("short_loss_sel",   int'(sel_ref),      0);

        // 3. Loss for hold-off drops ref 0, switch to ref 1.
        clk_loss[0] = 1'b1;
        push(1, 1, 1);
        ticks(2);
        check("holdoff_qual0", int'(qualified[0]), 0);
        check("holdoff_sel",   int'(sel_ref),      1);

        // 4a. Revertive return after WTR.
        clk_loss[0] = 1'b0;
        push(0, 1, 1);
        ticks(4);
        check("revert_wait_sel", int'(sel_ref), 1);
        ticks(1);
        check("revert_qual0", int'(qualified[0]), 1);
        check("revert_sel",   int'(sel_ref),      0);

        // 4b. Non-revertive stays on ref 1; enabling revertive then switches.
        clk_loss[0] = 1'b1;
        push(1, 1, 1);
        ticks(2);
        revertive   = 1'b0;
        clk_loss[0] = 1'b0;
        ticks(5);
        check("nonrev_qual0", int'(qualified[0]), 1);
        check("nonrev_sel",   int'(sel_ref),      1);
        push(0, 1, 1);
        revertive = 1'b1;
        repeat (3) @(negedge clk);
        check("rev_enable_sel", int'(sel_ref), 0);

        // 5. All lost -> HOLDOVER; ref 3 recovers -> LOCKED at 3.
        clk_loss = '1;
        push(0, 2, 0);
        ticks(2);
        check("holdover_state", int'(arb_state), 2);
        check("holdover_valid", int'(sel_valid), 0);
        clk_loss = ~11'h008;
        push(3, 1, 1);
        ticks(4);
        check("holdover_wait_state", int'(arb_state), 2);
        ticks(1);
        check("recover_qual", int'(qualified), 11'h008);
        check("recover_sel",  int'(sel_ref),   3);

        // All recover; revertive returns to ref 0.
        clk_loss = '0;
        push(0, 1, 1);
        ticks(5);
        check("all_recover_qual", int'(qualified), 11'h7FF);
        check("all_recover_sel",  int'(sel_ref),   0);

        // 6. Manual selection.
`ifdef TIMING_REF_FORCE_EN
        push(4, 1, 1);
        force_sel = 4'd4;
        force_en  = 1'b1;
        repeat (3) @(negedge clk);
        check("force_sel_4", int'(sel_ref), 4);
        push(0, 1, 1);
        force_sel = 4'd12;
        repeat (3) @(negedge clk);
        check("force_out_of_range_sel", int'(sel_ref), 0);
        force_en = 1'b0;
`else
        force_sel = 4'd4;
        force_en  = 1'b1;
        repeat (3) @(negedge clk);
        check("force_ignored_sel", int'(sel_ref), 0);
        force_en = 1'b0;
`endif

        // Move off ref 0, then reset mid-run.
        clk_loss[0] = 1'b1;
        push(1, 1, 1);
        ticks(2);
        check("pre_rst_sel", int'(sel_ref), 1);
        @(negedge clk);
        rst      = 1'b1;
        clk_loss = '0;
        @(negedge clk);
        check("midrst_sel_ref",    int'(sel_ref),    0);
        check("midrst_sel_valid",  int'(sel_valid),  0);
        check("midrst_arb_state",  int'(arb_state),  0);
        check("midrst_qualified",  int'(qualified),  0);
        check("midrst_switch_evt", int'(switch_evt), 0);
        rst = 1'b0;
        push(0, 1, 1);
        ticks(4);
        check("post_rst_wtr_unqual", int'(qualified), 0);
        ticks(1);
        check("post_rst_wtr_qual", int'(qualified), 11'h7FF);

        repeat (5) @(negedge clk);
        check("pending_switches", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
